// File: rtl/textlcd_pkg.sv
// -----------------------------------------------------------------------------
// textlcd_pkg
// Shared constants for the text-LCD AXI4-Lite slave: register word indices,
// STATUS bit positions, sequencer state codes, AXI response codes and a helper
// that sizes the sequencer down-counter.
// -----------------------------------------------------------------------------
package textlcd_pkg;

    // Register word index (byte address bits [3:2])
    localparam logic [1:0] REG_CMD     = 2'd0;  // 0x0
    localparam logic [1:0] REG_CHAR    = 2'd1;  // 0x4
    localparam logic [1:0] REG_STATUS  = 2'd2;  // 0x8
    localparam logic [1:0] REG_SCRATCH = 2'd3;  // 0xC

    // STATUS bit positions
    localparam int STAT_BUSY    = 0;
    localparam int STAT_OVERRUN = 1;
    localparam int STAT_DONE    = 2;

    // Sequencer states
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SETUP = 2'd1;
    localparam logic [1:0] ST_PULSE = 2'd2;
    localparam logic [1:0] ST_EXEC  = 2'd3;

    // AXI responses
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Width of a down-counter able to hold the largest of the three phase lengths
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/textlcd_axi_if.sv
// -----------------------------------------------------------------------------
// textlcd_axi_if
// AXI4-Lite bundle between the interconnect (master) and the text-LCD slave.
// Channels: AW (awaddr/awprot/awvalid/awready), W (wdata/wstrb/wvalid/wready),
// B (bresp/bvalid/bready), AR (araddr/arprot/arvalid/arready),
// R (rdata/rresp/rvalid/rready).
// -----------------------------------------------------------------------------
interface textlcd_axi_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   awaddr;
    logic [2:0]          awprot;
    logic                awvalid;
    logic                awready;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wvalid;
    logic                wready;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;
    logic [ADDR_W-1:0]   araddr;
    logic [2:0]          arprot;
    logic                arvalid;
    logic                arready;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rvalid;
    logic                rready;

    modport slave (
        input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
               araddr, arprot, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport master (
        output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
               araddr, arprot, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/textlcd_bus_seq.sv
// -----------------------------------------------------------------------------
// textlcd_bus_seq
// HD44780-style write-cycle sequencer: IDLE -> SETUP -> PULSE -> EXEC -> IDLE.
// Ports: clk, rst_n (async active-low); start_i launches a cycle using rs_i and
// data_i (latched at launch); busy_o = not idle; done_o pulses on the clock the
// cycle leaves EXEC; lcd_rs_o/lcd_e_o/lcd_data_o drive the LCD pins.
// -----------------------------------------------------------------------------
module textlcd_bus_seq
    import textlcd_pkg::*;
#(
    parameter int T_SETUP = 4,
    parameter int T_PULSE = 25,
    parameter int T_EXEC  = 4000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start_i,
    input  logic       rs_i,
    input  logic [7:0] data_i,
    output logic       busy_o,
    output logic       done_o,
    output logic       lcd_rs_o,
    output logic       lcd_e_o,
    output logic [7:0] lcd_data_o
);
    localparam int CW = cnt_width(T_SETUP, T_PULSE, T_EXEC);

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          e_q, e_d;
    logic          rs_q, rs_d;
    logic [7:0]    data_q, data_d;

    always_comb begin
        // NOTE: every _d starts at its current value so no path leaves it unassigned (no latch).
        state_d = state_q;
        cnt_d   = cnt_q;
        e_d     = e_q;
        rs_d    = rs_q;
        data_d  = data_q;
        done_o  = 1'b0;
        case (state_q)
            ST_IDLE: if (start_i) begin
                state_d = ST_SETUP;
                cnt_d   = CW'(T_SETUP - 1);
                rs_d    = rs_i;
                data_d  = data_i;
            end
            ST_SETUP: if (cnt_q == '0) begin
                state_d = ST_PULSE;
                cnt_d   = CW'(T_PULSE - 1);
                e_d     = 1'b1;
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
            ST_PULSE: if (cnt_q == '0) begin
                state_d = ST_EXEC;
                cnt_d   = CW'(T_EXEC - 1);
                e_d     = 1'b0;
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
            default: if (cnt_q == '0) begin  // ST_EXEC
                state_d = ST_IDLE;
                done_o  = 1'b1;
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
        endcase
    end

    // E is a flop (not a state decode) so the strobe is glitch-free and drops
    // straight away on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            e_q     <= 1'b0;
            rs_q    <= 1'b0;
            data_q  <= 8'h00;
        end else begin
            // NOTE: non-blocking so every flop updates from the same pre-edge values.
            state_q <= state_d;
            cnt_q   <= cnt_d;
            e_q     <= e_d;
            rs_q    <= rs_d;
            data_q  <= data_d;
        end
    end

    assign busy_o     = (state_q != ST_IDLE);
    assign lcd_rs_o   = rs_q;
    assign lcd_e_o    = e_q;
    assign lcd_data_o = data_q;

endmodule

// File: rtl/textlcd_axi_slave.sv
// -----------------------------------------------------------------------------
// textlcd_axi_slave
// AXI4-Lite register slave driving an HD44780-style text LCD.
// Ports: s00_axi_aclk, s00_axi_aresetn (async active-low); s00_axi (AXI4-Lite
// slave modport); lcd_rs/lcd_rw/lcd_e/lcd_data LCD pins; irq (done interrupt,
// present only when TEXTLCD_IRQ_EN is defined).
// Registers: 0x0 CMD, 0x4 CHAR, 0x8 STATUS {done,overrun,busy}, 0xC SCRATCH.
// -----------------------------------------------------------------------------
module textlcd_axi_slave
    import textlcd_pkg::*;
#(
    parameter int C_S00_AXI_DATA_WIDTH = 32,
    parameter int C_S00_AXI_ADDR_WIDTH = 4,
    parameter int T_SETUP              = 4,
    parameter int T_PULSE              = 25,
    parameter int T_EXEC               = 4000
) (
    input  logic          s00_axi_aclk,
    input  logic          s00_axi_aresetn,
    textlcd_axi_if.slave  s00_axi,
    output logic          lcd_rs,
    output logic          lcd_rw,
    output logic          lcd_e,
    output logic [7:0]    lcd_data
`ifdef TEXTLCD_IRQ_EN
    ,
    output logic          irq
`endif
);
    localparam int DW = C_S00_AXI_DATA_WIDTH;

    logic          awready_q, awready_d;
    logic          bvalid_q, bvalid_d;
    logic [1:0]    bresp_q, bresp_d;
    logic          arready_q, arready_d;
    logic          rvalid_q, rvalid_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic [DW-1:0] cmd_q, cmd_d, char_q, char_d, scratch_q, scratch_d;
    logic          overrun_q, overrun_d, done_q, done_d;
    logic          start_q, start_d, start_rs_q, start_rs_d;
    logic          seq_busy, seq_done, lcd_busy, wr_fire, rd_fire;
    logic [1:0]    wr_idx, rd_idx;
    logic [DW-1:0] status_w;

    assign wr_idx   = s00_axi.awaddr[C_S00_AXI_ADDR_WIDTH-1 -: 2];
    assign rd_idx   = s00_axi.araddr[C_S00_AXI_ADDR_WIDTH-1 -: 2];
    assign wr_fire  = awready_q && s00_axi.awvalid && s00_axi.wvalid;
    assign rd_fire  = arready_q && s00_axi.arvalid;
    // A launch is in flight one clock before the sequencer leaves IDLE.
    assign lcd_busy = seq_busy || start_q;
    assign status_w = {{(DW-3){1'b0}}, done_q, overrun_q, seq_busy};

    always_comb begin
        awready_d  = !awready_q && s00_axi.awvalid && s00_axi.wvalid && !bvalid_q;
        arready_d  = !arready_q && s00_axi.arvalid && !rvalid_q;
        bvalid_d   = bvalid_q;
        bresp_d    = bresp_q;
        rvalid_d   = rvalid_q;
        rdata_d    = rdata_q;
        cmd_d      = cmd_q;
        char_d     = char_q;
        scratch_d  = scratch_q;
        overrun_d  = overrun_q;
        done_d     = done_q;
        start_d    = 1'b0;
        start_rs_d = start_rs_q;

        if (bvalid_q && s00_axi.bready) bvalid_d = 1'b0;
        if (wr_fire) begin
            bvalid_d = 1'b1;
            bresp_d  = RESP_OKAY;
            case (wr_idx)
                REG_CMD, REG_CHAR: begin
                    if (lcd_busy) begin
                        overrun_d = 1'b1;
                        bresp_d   = RESP_SLVERR;
                    end else begin
                        if (wr_idx == REG_CMD) cmd_d  = s00_axi.wdata;
                        else                   char_d = s00_axi.wdata;
                        start_d    = 1'b1;
                        start_rs_d = (wr_idx == REG_CHAR);
                    end
                end
                REG_STATUS: if (s00_axi.wstrb[0]) begin
                    if (s00_axi.wdata[STAT_OVERRUN]) overrun_d = 1'b0;
                    if (s00_axi.wdata[STAT_DONE])    done_d    = 1'b0;
                end
                default: begin
                    for (int b = 0; b < DW/8; b++)
                        if (s00_axi.wstrb[b]) scratch_d[8*b +: 8] = s00_axi.wdata[8*b +: 8];
                end
            endcase
        end
        // Placed after the W1C so a coinciding clear loses to the new event.
        if (seq_done) done_d = 1'b1;

        if (rvalid_q && s00_axi.rready) rvalid_d = 1'b0;
        if (rd_fire) begin
            rvalid_d = 1'b1;
            case (rd_idx)
                REG_CMD:    rdata_d = cmd_q;
                REG_CHAR:   rdata_d = char_q;
                REG_STATUS: rdata_d = status_w;
                default:    rdata_d = scratch_q;
            endcase
        end
    end

    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            awready_q  <= 1'b0;
            bvalid_q   <= 1'b0;
            bresp_q    <= RESP_OKAY;
            arready_q  <= 1'b0;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
            // NOTE: the register file is a few flops, so it is reset here; a RAM array would not be.
            cmd_q      <= '0;
            char_q     <= '0;
            scratch_q  <= '0;
            overrun_q  <= 1'b0;
            done_q     <= 1'b0;
            start_q    <= 1'b0;
            start_rs_q <= 1'b0;
        end else begin
            awready_q  <= awready_d;
            bvalid_q   <= bvalid_d;
            bresp_q    <= bresp_d;
            arready_q  <= arready_d;
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
            cmd_q      <= cmd_d;
            char_q     <= char_d;
            scratch_q  <= scratch_d;
            overrun_q  <= overrun_d;
            done_q     <= done_d;
            start_q    <= start_d;
            start_rs_q <= start_rs_d;
        end
    end

    textlcd_bus_seq #(
        .T_SETUP (T_SETUP),
        .T_PULSE (T_PULSE),
        .T_EXEC  (T_EXEC)
    ) u_seq (
        .clk        (s00_axi_aclk),
        .rst_n      (s00_axi_aresetn),
        .start_i    (start_q),
        .rs_i       (start_rs_q),
        .data_i     (start_rs_q ? char_q[7:0] : cmd_q[7:0]),
        .busy_o     (seq_busy),
        .done_o     (seq_done),
        .lcd_rs_o   (lcd_rs),
        .lcd_e_o    (lcd_e),
        .lcd_data_o (lcd_data)
    );

    assign s00_axi.awready = awready_q;
    assign s00_axi.wready  = awready_q;
    assign s00_axi.bvalid  = bvalid_q;
    assign s00_axi.bresp   = bresp_q;
    assign s00_axi.arready = arready_q;
    assign s00_axi.rvalid  = rvalid_q;
    assign s00_axi.rdata   = rdata_q;
    assign s00_axi.rresp   = RESP_OKAY;
    assign lcd_rw          = 1'b0;
`ifdef TEXTLCD_IRQ_EN
    assign irq             = done_q;
`endif

    logic unused_ok;
    assign unused_ok = ^{s00_axi.awprot, s00_axi.arprot,
                         s00_axi.awaddr[C_S00_AXI_ADDR_WIDTH-3:0],
                         s00_axi.araddr[C_S00_AXI_ADDR_WIDTH-3:0]};

endmodule

// File: tb/tb_textlcd_axi_slave.sv
// -----------------------------------------------------------------------------
// tb_textlcd_axi_slave
// Self-checking bench for textlcd_axi_slave (default T_* values). Connects irq
// only when TEXTLCD_IRQ_EN is defined.
// -----------------------------------------------------------------------------
module tb_textlcd_axi_slave;
    import textlcd_pkg::*;

    localparam int T_SETUP   = 4;
    localparam int T_PULSE   = 25;
    localparam int T_EXEC    = 4000;
    localparam int CYCLE_LEN = T_SETUP + T_PULSE + T_EXEC;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    textlcd_axi_if #(.ADDR_W(4), .DATA_W(32)) axi ();
    logic       lcd_rs, lcd_rw, lcd_e;
    logic [7:0] lcd_data;
`ifdef TEXTLCD_IRQ_EN
    logic       irq;
`endif

    textlcd_axi_slave #(
        .C_S00_AXI_DATA_WIDTH (32),
        .C_S00_AXI_ADDR_WIDTH (4),
        .T_SETUP (T_SETUP), .T_PULSE (T_PULSE), .T_EXEC (T_EXEC)
    ) dut (
        .s00_axi_aclk    (clk),
        .s00_axi_aresetn (rst_n),
        .s00_axi         (axi),
        .lcd_rs          (lcd_rs),
        .lcd_rw          (lcd_rw),
        .lcd_e           (lcd_e),
        .lcd_data        (lcd_data)
`ifdef TEXTLCD_IRQ_EN
        ,.irq            (irq)
`endif
    );

    int cyc = 0;  // number of rising edges seen so far
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural register model
    logic [31:0] m_cmd, m_char, m_scratch;
    bit          m_overrun, m_done;

    function automatic logic [31:0] m_status(input bit busy);
        return {29'd0, m_done, m_overrun, busy};
    endfunction

    function automatic logic [31:0] m_read(input logic [3:0] addr);
        case (addr[3:2])
            2'd0:    return m_cmd;
            2'd1:    return m_char;
            2'd2:    return m_status(1'b0);
            default: return m_scratch;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: timed out", name);
    endtask

    task automatic wait_edge(input int t);
        while (cyc < t) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic axi_write(input logic [3:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, output logic [1:0] resp, output int acc);
        int n;
        axi.awaddr = addr; axi.awprot = 3'b0; axi.awvalid = 1'b1;
        axi.wdata  = data; axi.wstrb  = strb; axi.wvalid  = 1'b1;
        axi.bready = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!axi.awready && n < 50);
        if (!axi.awready) timeout("write accept");
        @(posedge clk); #1;
        acc = cyc;
        axi.awvalid = 1'b0; axi.wvalid = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (!axi.bvalid && n < 20);
        if (!axi.bvalid) timeout("write response");
        resp = axi.bresp;
        @(posedge clk); #1;
    endtask

    task automatic axi_read(input logic [3:0] addr, output logic [31:0] data, output int r_edge);
        int n;
        axi.araddr = addr; axi.arprot = 3'b0; axi.arvalid = 1'b1; axi.rready = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (!axi.arready && n < 50);
        if (!axi.arready) timeout("read accept");
        @(posedge clk); #1;
        r_edge = cyc;
        axi.arvalid = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (!axi.rvalid && n < 20);
        if (!axi.rvalid) timeout("read data");
        data = axi.rdata;
        axi.rready = 1'b1;
        @(posedge clk); #1;
        axi.rready = 1'b0;
    endtask

    // Observe one E strobe: edge index of the rise, width in clocks, RS/DATA during E.
    task automatic measure_pulse(output int rise, output int width,
                                 output logic rs_at, output logic [7:0] data_at);
        int n;
        rise = -1; width = 0; rs_at = 1'bx; data_at = 8'hxx; n = 0;
        while (n < 200) begin
            @(posedge clk); #1; n++;
            if (lcd_e) begin
                if (rise < 0) begin rise = cyc; rs_at = lcd_rs; data_at = lcd_data; end
                width++;
            end else if (rise >= 0) begin
                break;
            end
        end
        if (rise < 0 || lcd_e) timeout("E strobe");
    endtask

    typedef struct {
        logic [3:0]  addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [1:0]  exp_resp;
        logic [31:0] exp_rd;
    } vec_t;

    initial begin
        vec_t        vecs [6];
        logic [1:0]  resp;
        logic [31:0] rd, d;
        logic [3:0]  a, s;
        logic        rs_at;
        logic [7:0]  data_at;
        int          acc, acc2, re, rise, width, n, aw_hi, w_hi, bv_hi;

        vecs[0] = '{4'hC, 32'h12345678, 4'b0011, RESP_OKAY, 32'h00005678};
        vecs[1] = '{4'hC, 32'hAABBCCDD, 4'b1100, RESP_OKAY, 32'hAABB5678};
        vecs[2] = '{4'hC, 32'hFFFFFFFF, 4'b0000, RESP_OKAY, 32'hAABB5678};
        vecs[3] = '{4'hC, 32'h01020304, 4'b0100, RESP_OKAY, 32'hAA025678};
        vecs[4] = '{4'h8, 32'hFFFFFFFF, 4'b1111, RESP_OKAY, 32'h00000000};
        vecs[5] = '{4'hC, 32'hCAFEF00D, 4'b1111, RESP_OKAY, 32'hCAFEF00D};

        axi.awaddr = '0; axi.awprot = '0; axi.awvalid = 1'b0;
        axi.wdata = '0; axi.wstrb = '0; axi.wvalid = 1'b0; axi.bready = 1'b0;
        axi.araddr = '0; axi.arprot = '0; axi.arvalid = 1'b0; axi.rready = 1'b0;
        m_cmd = '0; m_char = '0; m_scratch = '0; m_overrun = 0; m_done = 0;

        // ---------------- reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset outputs",
              {axi.awready, axi.wready, axi.bvalid, axi.arready, axi.rvalid,
               lcd_e, lcd_rs, lcd_rw, lcd_data, axi.rdata}, '0);
`ifdef TEXTLCD_IRQ_EN
        check("reset irq", irq, 0);
`endif
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) begin
            a = 4'(i * 4);
            axi_read(a, rd, re);
            check($sformatf("reset read 0x%0h", a), rd, 32'h0);
        end

        // ---------------- table-driven register vectors
        for (int i = 0; i < 6; i++) begin
            axi_write(vecs[i].addr, vecs[i].wdata, vecs[i].wstrb, resp, acc);
            check($sformatf("vec%0d bresp", i), resp, vecs[i].exp_resp);
            axi_read(vecs[i].addr, rd, re);
            check($sformatf("vec%0d readback", i), rd, vecs[i].exp_rd);
        end
        m_scratch = 32'hCAFEF00D;

        // ---------------- CMD write: full LCD cycle, overrun while busy
        axi_write(4'h0, 32'h38, 4'hF, resp, acc);
        check("CMD bresp", resp, RESP_OKAY);
        m_cmd = 32'h38;
        measure_pulse(rise, width, rs_at, data_at);
        check("E rise delay", rise - acc, T_SETUP + 1);
        check("E width", width, T_PULSE);
        check("RS for CMD", rs_at, 0);
        check("DATA for CMD", data_at, 8'h38);
        axi_write(4'h4, 32'h41, 4'hF, resp, acc2);
        check("CHAR while busy bresp", resp, RESP_SLVERR);
        m_overrun = 1;
        check("lcd_data held", {lcd_rs, lcd_data}, {1'b0, 8'h38});
        axi_read(4'h8, rd, re);
        check("STATUS busy+overrun", rd, m_status(1'b1));
        axi_read(4'h4, rd, re);
        check("dropped CHAR not stored", rd, m_char);
        axi_read(4'h0, rd, re);
        check("CMD readback", rd, m_cmd);
        // Last clock of EXEC, then first clock after it.
        wait_edge(acc + CYCLE_LEN - 1);
        axi_read(4'h8, rd, re);
        check("read sample edge", re - acc, CYCLE_LEN + 1);
        check("STATUS last busy clock", rd, m_status(1'b1));
        axi_read(4'h8, rd, re);
        m_done = 1;
        check("STATUS done after cycle", rd, m_status(1'b0));

        // ---------------- randomized register traffic vs model
        for (int i = 0; i < 50; i++) begin
            n = $urandom_range(0, 9);
            if (n < 5) begin
                d = $urandom; s = 4'($urandom_range(0, 15));
                axi_write(4'hC, d, s, resp, acc2);
                check("rand SCRATCH bresp", resp, RESP_OKAY);
                for (int b = 0; b < 4; b++)
                    if (s[b]) m_scratch[8*b +: 8] = d[8*b +: 8];
            end else if (n < 7) begin
                d = $urandom;
                axi_write(4'h8, d, 4'hF, resp, acc2);
                check("rand STATUS bresp", resp, RESP_OKAY);
                if (d[1]) m_overrun = 0;
                if (d[2]) m_done = 0;
            end else begin
                a = 4'($urandom_range(0, 3) * 4);
                axi_read(a, rd, re);
                check($sformatf("rand read 0x%0h", a), rd, m_read(a));
            end
        end
`ifdef TEXTLCD_IRQ_EN
        check("irq follows done", irq, m_done);
`endif
        axi_write(4'h8, 32'h6, 4'hF, resp, acc2);
        m_overrun = 0; m_done = 0;
        axi_read(4'h8, rd, re);
        check("STATUS after W1C", rd, 32'h0);
`ifdef TEXTLCD_IRQ_EN
        check("irq cleared", irq, 0);
`endif

        // ---------------- AW before W, delayed BREADY
        axi.awaddr = 4'hC; axi.awvalid = 1'b1; axi.wvalid = 1'b0; axi.bready = 1'b0;
        aw_hi = 0; w_hi = 0; bv_hi = 0;
        repeat (3) begin
            @(negedge clk);
            if (axi.awready) aw_hi++;
            if (axi.wready) w_hi++;
        end
        axi.wdata = 32'h5A5A0000; axi.wstrb = 4'hF; axi.wvalid = 1'b1;
        n = 0;
        while (!axi.bvalid && n < 20) begin
            @(negedge clk); n++;
            if (axi.awready) aw_hi++;
            if (axi.wready) w_hi++;
            if (axi.awready) begin
                @(posedge clk); #1;
                axi.awvalid = 1'b0; axi.wvalid = 1'b0;
            end
        end
        if (!axi.bvalid) timeout("split write response");
        repeat (5) begin
            @(negedge clk);
            if (axi.bvalid && axi.bresp == RESP_OKAY) bv_hi++;
            if (axi.awready) aw_hi++;
        end
        check("single AW/W accept", {aw_hi[7:0], w_hi[7:0]}, {8'd1, 8'd1});
        check("bvalid held until bready", bv_hi, 5);
        axi.bready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check("bvalid drops after bready", axi.bvalid, 0);
        m_scratch = 32'h5A5A0000;
        axi_read(4'hC, rd, re);
        check("split write readback", rd, m_scratch);

        // ---------------- reset during PULSE
        axi_write(4'h0, 32'h55, 4'hF, resp, acc);
        n = 0;
        while (!lcd_e && n < 50) begin @(posedge clk); #1; n++; end
        if (!lcd_e) timeout("E before reset");
        axi.araddr = 4'hC; axi.arvalid = 1'b1; axi.rready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        axi.arvalid = 1'b0;
        check("pending R before reset", {axi.rvalid, lcd_e}, 2'b11);
        #2;
        rst_n = 1'b0;
        #1;
        check("E drops on reset", lcd_e, 0);
        check("responses discarded", {axi.rvalid, axi.bvalid}, 2'b00);
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b1;
        m_cmd = '0; m_char = '0; m_scratch = '0; m_overrun = 0; m_done = 0;
        @(posedge clk); #1;
        axi_read(4'h8, rd, re);
        check("STATUS after reset", rd, 32'h0);
        axi_read(4'hC, rd, re);
        check("SCRATCH after reset", rd, m_scratch);

        // ---------------- full CHAR cycle after reset
        axi_write(4'h4, 32'h41, 4'hF, resp, acc);
        check("CHAR after reset bresp", resp, RESP_OKAY);
        m_char = 32'h41;
        measure_pulse(rise, width, rs_at, data_at);
        check("post-reset E rise delay", rise - acc, T_SETUP + 1);
        check("post-reset E width", width, T_PULSE);
        check("post-reset RS/DATA", {rs_at, data_at}, {1'b1, 8'h41});
        wait_edge(acc + CYCLE_LEN + 2);
        axi_read(4'h8, rd, re);
        m_done = 1;
        check("post-reset STATUS done", rd, m_status(1'b0));
`ifdef TEXTLCD_IRQ_EN
        check("post-reset irq", irq, 1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
